// File: rtl/seg7_pkg.sv
// Shared definitions for the stopwatch seven-segment scan driver.
// Holds the active-low segment patterns (bit order g..a), the blank
// and all-anodes-off constants, the digit/index types, and a helper
// that builds the active-low anode pattern for one digit slot.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] digit_t;
  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Exactly one low bit, at position idx.
  function automatic logic [3:0] an_select(input digit_idx_t idx);
    return AN_OFF & ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to seven-segment decoder, active-low outputs.
// Ports:
//   i_digit  4-bit value 0..F
//   o_seg    7-bit cathode pattern, [6:0] = g..a, low = segment on
module hex_to_seg7
  import seg7_pkg::*;
(
  input  digit_t     i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver for the stopwatch.
// Scans the digits one at a time (SCAN_DIV clk per digit), latches a
// whole frame of digit values at the start of each frame so a frame is
// never a mix of old and new values, and blinks the masked digits while
// adjust mode is active. All outputs are registered.
// Optional build macro SEG_DP_EN: drives seg[7] from the per-digit dp
// request; without it dp is ignored and seg[7] stays 1.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   digits      [3:0] digit 0 (rightmost) .. [15:12] digit 3 (leftmost)
//   blink_en    adjust mode active
//   blink_mask  bit i selects digit i for blinking
//   dp          per-digit decimal point request (SEG_DP_EN only)
//   seg         active-low cathodes, [6:0] = g..a, [7] = dp
//   an          active-low anodes, an[i] low lights digit i
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic        blink_en,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  r_scan_cnt;
  digit_idx_t         r_idx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase;
  logic [15:0]        r_digits_sh;

  logic       w_scan_tick;
  logic       w_frame_wrap;
  logic       w_blink_wrap;
  logic       w_blank;
  logic       w_dp_bit;
  digit_t     w_digit;
  logic [6:0] w_seg;

  assign w_scan_tick  = (r_scan_cnt == SCAN_LAST);
  assign w_frame_wrap = w_scan_tick && (r_idx == digit_idx_t'(NUM_DIGITS - 1));
  assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);

  // blink_en/blink_mask are used live so adjust-mode changes show up
  // on the very next output update.
  assign w_blank = blink_en & blink_mask[r_idx] & ~r_phase;

  assign w_digit = r_digits_sh[{r_idx, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .i_digit (w_digit),
    .o_seg   (w_seg)
  );

  // ---- stage 0: scan/blink timing and frame shadow ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (w_scan_tick) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + digit_idx_t'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  // Free-running, independent of blink_en, so the blink rhythm does not
  // restart whenever adjust mode is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (w_blink_wrap) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  // Capture on the 3->0 wrap: the whole next frame uses one snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits_sh <= '0;
    end else if (w_frame_wrap) begin
      r_digits_sh <= digits;
    end
  end

`ifdef SEG_DP_EN
  logic [3:0] r_dp_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_sh <= '0;
    end else if (w_frame_wrap) begin
      r_dp_sh <= dp;
    end
  end

  assign w_dp_bit = ~r_dp_sh[r_idx];
`else
  logic [3:0] w_dp_unused;

  assign w_dp_unused = dp;
  assign w_dp_bit    = 1'b1;
`endif

  // ---- stage 1: registered anode/cathode outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= 8'hFF;
    end else if (w_blank) begin
      an  <= AN_OFF;
      seg <= {1'b1, SEG_BLANK};
    end else begin
      an  <= an_select(r_idx);
      seg <= {w_dp_bit, w_seg};
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic        blink_en = 1'b0;
  logic [3:0]  blink_mask = 4'b0000;
  logic [3:0]  dp = 4'b0000;
  logic [7:0]  seg;
  logic [3:0]  an;

  int tests = 0;
  int fails = 0;
  int cyc;

  seg7_scan_driver #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits     (digits),
    .blink_en   (blink_en),
    .blink_mask (blink_mask),
    .dp         (dp),
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset release (edge 1 = first edge after release).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  typedef struct {
    logic [15:0] digits;
    logic [27:0] exp;   // {digit3, digit2, digit1, digit0} patterns, g..a
  } vec_t;

  vec_t vecs [4];

  localparam logic [27:0] ZEROS = {4{7'b1000000}};
  localparam logic [27:0] EIGHTS = {4{7'b0000000}};
  localparam logic [27:0] EFFS = {4{7'b0001110}};
  localparam logic [27:0] P1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at the negedge of the first cycle of slot 'first'; checks each
  // remaining slot for its full 4 cycles and returns at the next frame start.
  task automatic check_slots(input int first, input logic [27:0] segs,
                             input logic [3:0] dpv, input string tag);
    logic [3:0] ea;
    logic [7:0] es;
    logic       e7;
    for (int s = first; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        ea = ~(4'b0001 << s);
`ifdef SEG_DP_EN
        e7 = ~dpv[s];
`else
        e7 = 1'b1;
`endif
        es = {e7, segs[s*7 +: 7]};
        chk($sformatf("%s an s%0d c%0d", tag, s, c), {28'd0, an}, {28'd0, ea});
        chk($sformatf("%s seg s%0d c%0d", tag, s, c), {24'd0, seg}, {24'd0, es});
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_frame_start();
    logic [3:0] prev;
    int n;
    bit done;
    prev = an;
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (an == 4'b1110 && prev != 4'b1110) begin
        done = 1;
      end else if (n >= 100) begin
        tests++;
        fails++;
        $display("FAIL frame_sync: no frame start within %0d cycles", n);
        done = 1;
      end
      prev = an;
    end
  endtask

  // Cycle model of the blink window; digits fixed at 8888, dp = 0.
  task automatic check_blink_window(input string tag, input int exp_blank);
    int slot, nblank;
    bit ph, blank;
    logic [3:0] ea;
    logic [7:0] es;
    nblank = 0;
    for (int k = 0; k < 64; k++) begin
      slot  = ((cyc - 1) / 4) % 4;
      ph    = (((cyc - 1) / 32) % 2) == 0;
      blank = blink_en && blink_mask[slot] && !ph;
      ea    = blank ? 4'hF : ~(4'b0001 << slot);
      es    = blank ? 8'hFF : 8'h80;
      chk($sformatf("%s an k%0d", tag, k), {28'd0, an}, {28'd0, ea});
      chk($sformatf("%s seg k%0d", tag, k), {24'd0, seg}, {24'd0, es});
      if (an == 4'hF) nblank++;
      @(negedge clk);
    end
    chk({tag, " blank_count"}, nblank, exp_blank);
  endtask

  initial begin
    vecs[0] = '{16'h5678, {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}};
    vecs[1] = '{16'h9ABC, {7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110}};
    vecs[2] = '{16'hDEF0, {7'b0100001, 7'b0000110, 7'b0001110, 7'b1000000}};
    vecs[3] = '{16'h3210, {7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000}};

    // Reset held for 3 clocks
    repeat (3) @(negedge clk);
    chk("reset an", {28'd0, an}, 32'hF);
    chk("reset seg", {24'd0, seg}, 32'hFF);
    digits = 16'h1234;
    rst_n = 1'b1;

    // First frame shows zeros (shadow not yet loaded), slots 1110..0111 x4
    @(negedge clk);
    check_slots(0, ZEROS, 4'b0000, "frame1");
    // Second frame shows the captured 1234
    check_slots(0, P1234, 4'b0000, "frame2");

    // Tearing: change at index 2 must not affect the current frame
    digits = 16'h0000;
    wait_frame_start();
    wait_frame_start();
    repeat (8) @(negedge clk);
    digits = 16'hFFFF;
    check_slots(2, ZEROS, 4'b0000, "tear_old");
    check_slots(0, EFFS, 4'b0000, "tear_new");

    // Decode table
    for (int i = 0; i < 4; i++) begin
      digits = vecs[i].digits;
      wait_frame_start();
      wait_frame_start();
      check_slots(0, vecs[i].exp, 4'b0000, $sformatf("vec%0d", i));
    end

    // Blink on digits 3 and 2
    digits = 16'h8888;
    blink_en = 1'b1;
    blink_mask = 4'b1100;
    wait_frame_start();
    wait_frame_start();
    check_blink_window("blink_on", 16);

    // blink_en low overrides the mask
    blink_en = 1'b0;
    @(negedge clk);
    check_blink_window("blink_off", 0);
    blink_mask = 4'b0000;

    // Decimal point on digit 1
    dp = 4'b0010;
    wait_frame_start();
    wait_frame_start();
    check_slots(0, EIGHTS, 4'b0010, "dp");
    dp = 4'b0000;

    // Asynchronous reset in the middle of slot 2
    wait_frame_start();
    repeat (8) @(negedge clk);
    chk("pre_rst an", {28'd0, an}, 32'hB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst an", {28'd0, an}, 32'hF);
    chk("async_rst seg", {24'd0, seg}, 32'hFF);
    @(negedge clk);
    @(negedge clk);
    chk("held_rst an", {28'd0, an}, 32'hF);
    rst_n = 1'b1;
    @(negedge clk);
    check_slots(0, ZEROS, 4'b0000, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Output-side board I/O block for the stopwatch: drives the 4-digit multiplexed seven-segment display from the clock/control logic, which consumes the debounced PAUSE/RESET/ADJ/SEL inputs.
- Time-multiplexes four 4-bit digit values onto shared cathodes with active-low anodes.
- Blinks the digits selected for adjustment while in adjust mode.
- All outputs are registered.

Parameters:
- SCAN_DIV, 100000, clk cycles each digit is lit (1 ms at 100 MHz); must be >= 2.
- BLINK_DIV, 25000000, clk cycles per blink half-period (0.25 s at 100 MHz, 2 Hz blink); must be >= 2.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- digits  in  16  digit values; [3:0] = digit 0 (rightmost) … [15:12] = digit 3 (leftmost); values 0–F.
- blink_en  in  1  adjust mode active (driven by ADJ).
- blink_mask  in  4  per-digit blink select (bit i = digit i); SEL picks {3,2} or {1,0} upstream.
- dp  in  4  per-digit decimal point request; used only with SEG_DP_EN.
- seg  out  8  active-low cathodes; [6:0] = g..a, [7] = dp.
- an  out  4  active-low anodes; an[i] low lights digit i.

Behaviour:
- Reset (rst_n low, async): an = 4'b1111, seg = 8'hFF, scan counter = 0, digit index = 0, blink counter = 0, blink phase = 1 (visible), shadow digits = 0.
- Scan counter: counts 0..SCAN_DIV-1, wraps to 0. A tick is the cycle the counter equals SCAN_DIV-1. On each tick, the index advances 0→1→2→3→0.
- Shadow register: when index wraps 3→0, digits and dp are copied into a shadow register in the same cycle. The display therefore never shows a torn mix of old and new values within one frame. After reset, the first capture happens at the first 3→0 wrap; until then the display shows zeros.
- Output register:
  - Each cycle, an and seg are loaded from the current index and shadow value.
  - Latency is one clk from an index change to the an/seg change.
  - an has exactly one zero bit, or is all ones when blanked; never two zeros.
- Decode:
  - Hex, active-low, standard patterns: 0 = 7'b1000000, 1 = 7'b1111001, … 9 = 7'b0010000, A = 7'b0001000, b = 7'b0000011, C = 7'b1000110, d = 7'b0100001, E = 7'b0000110, F = 7'b0001110.
- Blink:
  - Blink counter counts 0..BLINK_DIV-1 and toggles the phase on wrap. It free-runs regardless of blink_en.
  - When blink_en = 1, blink_mask[idx] = 1 and phase = 0: an = 4'b1111 and seg = 8'hFF for that slot. The scan keeps advancing normally.
  - blink_en and blink_mask are sampled live, not shadowed, so they take effect within one clk.
  - blink_en = 0 overrides the mask; all digits are lit.
- Simultaneous events: a scan tick in the same cycle as a blink wrap are independent and both take effect. A shadow capture in the same cycle as a digits change captures the new value.
- rst_n asserted mid-frame returns all state to reset values immediately. Scanning restarts at digit 0 on the first clk after deassertion.

Optional Feature:
- Macro: SEG_DP_EN.
- Defined: seg[7] = ~dp_shadow[idx] for the lit digit, forced to 1 when that slot is blinked off.
- Undefined: the dp port is still present but ignored; seg[7] is constant 1 after reset.

Decomposition:
- Package seg7_pkg:
  - NUM_DIGITS = 4.
  - Segment pattern constants SEG_0..SEG_F and SEG_BLANK = 7'h7F.
  - AN_OFF = 4'b1111.
  - Typedef digit_t (4-bit) and digit_idx_t (2-bit).
- Sub-module hex_to_seg7: combinational 4-bit to 7-bit active-low decoder, instantiated once on the shadowed selected digit.

Test Plan (SCAN_DIV = 4, BLINK_DIV = 32):
- Reset: hold rst_n = 0 for 3 clk → an = 4'hF, seg = 8'hFF. Release → the first anode pattern is 4'b1110, with each digit lit for exactly 4 clk in order 1110, 1101, 1011, 0111.
- Decode: digits = 16'h1234 stable over 2 frames → second frame shows an 0111 with seg[6:0] = 7'b1111001, and an 1110 with seg[6:0] = 7'b0011001; seg[7] = 1.
- Tearing: change digits 16'h0000 → 16'hFFFF while index = 2 → digits 2 and 3 still show 0 this frame; all digits show F (7'b0001110) from the next index 0.
- Blink: blink_en = 1, blink_mask = 4'b1100 → over 64 clk, digits 3 and 2 are blank (an = 4'hF in their slots) for exactly 32 consecutive clk and lit for 32. Digits 1 and 0 are always lit. With blink_en = 0, no blanking occurs.
- Async reset mid-scan: drop rst_n at index 2 between clock edges → an = 4'hF with no clk edge needed; after release, scanning restarts at 4'b1110.
- SEG_DP_EN: with the macro defined, dp = 4'b0010 and digits stable → seg[7] = 0 only while an = 4'b1101. With it undefined, seg[7] = 1 throughout.
